// File: rtl/fpu_buffer_ctrl.sv
// Column sequencer for the FPU three-column window buffers: primes three
// columns, then alternates one-column fetches with FPU window computations.
module fpu_buffer_ctrl #(
    parameter int COL_WIDTH = 10,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] img_cols,
    input  logic             abort,
    output logic             col_req,
    input  logic             col_valid,
    output logic             shift_rows,
    output logic             win_valid,
    input  logic             comp_done,
    output logic [CNT_W-1:0] col_idx,
    output logic             busy,
    output logic             done
);

    // Column depth lives in the buffers; it only has to be sane here.
    if (COL_WIDTH < 1) begin : g_col_width_check
        $error("fpu_buffer_ctrl: COL_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COMPUTE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_COLS  = CNT_W'(3);
    localparam logic [CNT_W-1:0] LAST_PRIM = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] cols_ld;
    logic [CNT_W-1:0] fetched;

    // The shift must land in the same cycle the fetch unit drives col_new,
    // so it cannot wait for a register; rst and abort both veto it.
    assign shift_rows = col_req & col_valid & ~abort & ~rst;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cols_ld   <= '0;
            fetched   <= '0;
            col_idx   <= '0;
            col_req   <= 1'b0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            col_req   <= 1'b0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (img_cols >= WIN_COLS) begin
                            cols_ld <= img_cols;
                            fetched <= '0;
                            col_req <= 1'b1;
                            state   <= REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (col_valid) begin
                        fetched <= fetched + ONE;
                        // Third column (or later) completes a window; the
                        // centre column is the one fetched just before it.
                        if (fetched >= LAST_PRIM) begin
                            col_idx   <= fetched - ONE;
                            col_req   <= 1'b0;
                            win_valid <= 1'b1;
                            state     <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (comp_done) begin
                        win_valid <= 1'b0;
                        if (fetched == cols_ld) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            col_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    col_req   <= 1'b0;
                    win_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_buffer_ctrl.sv
// Scoreboard bench for fpu_buffer_ctrl: expected window/done events are queued
// at stimulus time and matched against what the DUT produces.
module tb_fpu_buffer_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] img_cols;
    logic             abort;
    logic             col_req;
    logic             col_valid;
    logic             shift_rows;
    logic             win_valid;
    logic             comp_done;
    logic [CNT_W-1:0] col_idx;
    logic             busy;
    logic             done;

    fpu_buffer_ctrl #(.COL_WIDTH(10), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_cols   (img_cols),
        .abort      (abort),
        .col_req    (col_req),
        .col_valid  (col_valid),
        .shift_rows (shift_rows),
        .win_valid  (win_valid),
        .comp_done  (comp_done),
        .col_idx    (col_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        int shifts;
    } ev_t;

    ev_t exp_q[$];
    int  rd_ptr;
    int  n_cmp;
    int  n_bad;

    // Monitor state (written only by the monitor)
    int  cyc;
    int  shift_cnt;
    int  last_shift_cyc;
    int  last_cd_cyc;
    int  done_cnt;
    int  win_seen;
    int  any_act;
    bit  win_q;
    bit  req_q;
    bit  prev_shift;
    bit  prev_kill;

    // Test-owned knobs
    int  shift_base;
    int  cv_mode;   // 0: col_valid low, 1: tied high, 2: four-cycle wait per request
    bit  cd_noise;  // pulse comp_done while requesting

    int  req_wait;
    int  win_wait;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic take_event(input bit is_done);
        ev_t e;
        if (rd_ptr >= exp_q.size()) begin
            check(is_done ? "unexpected_done" : "unexpected_window", 1, 0);
        end else begin
            e = exp_q[rd_ptr];
            rd_ptr++;
            check("event_kind", int'(is_done), int'(e.is_done));
            check(is_done ? "shifts_at_done" : "shifts_at_window", shift_cnt - shift_base, e.shifts);
            if (!is_done) check("col_idx", int'(col_idx), e.idx);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (shift_rows || (col_req && col_valid))
            check("shift_eq_valid", int'(shift_rows), int'(col_req && col_valid && !rst && !abort));
        if (shift_rows) begin
            shift_cnt++;
            last_shift_cyc = cyc;
        end
        if (col_req || shift_rows || win_valid) any_act++;
        if (req_q && !col_req && !prev_kill) check("req_held_until_valid", int'(prev_shift), 1);
        if (col_req && !req_q && last_cd_cyc > 0) begin
            check("comp_done_to_req", cyc - last_cd_cyc, 1);
            last_cd_cyc = 0;
        end
        if (win_valid && !win_q) begin
            win_seen++;
            check("last_shift_to_window", cyc - last_shift_cyc, 1);
            take_event(1'b0);
        end
        if (comp_done && win_valid) last_cd_cyc = cyc;
        if (done) begin
            done_cnt++;
            last_cd_cyc = 0;
            take_event(1'b1);
        end
        win_q      = win_valid;
        req_q      = col_req;
        prev_shift = shift_rows;
        prev_kill  = rst || abort;
    end

    // Fetch unit and FPU models, driven just after each rising edge
    always @(posedge clk) begin
        #1;
        case (cv_mode)
            1: col_valid = 1'b1;
            2: begin
                if (col_valid) begin
                    col_valid = 1'b0;
                    req_wait  = 0;
                end else if (col_req) begin
                    req_wait++;
                    col_valid = (req_wait > 4);
                end else begin
                    req_wait = 0;
                end
            end
            default: col_valid = 1'b0;
        endcase
        if (win_valid) win_wait++;
        else win_wait = 0;
        comp_done = (win_wait == 3) || (cd_noise && col_req && cyc[0]);
    end

    task automatic push_ev(input bit is_done, input int idx, input int shifts);
        ev_t e;
        e.is_done = is_done;
        e.idx     = idx;
        e.shifts  = shifts;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        img_cols = CNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        if (n >= 3) check("start_to_req", int'(col_req), 1);
        else        check("start_to_done", int'(done), 1);
    endtask

    task automatic run_until_done(input int budget);
        int base;
        bit hit;
        base = done_cnt;
        hit  = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (done_cnt != base);
        end
        check("done_within_budget", int'(hit), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_col_req"},    int'(col_req),    0);
        check({tag, "_shift_rows"}, int'(shift_rows), 0);
        check({tag, "_win_valid"},  int'(win_valid),  0);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_done"},       int'(done),       0);
    endtask

    initial begin
        int base;
        bit hit;
        rst = 1'b1; start = 1'b0; img_cols = '0; abort = 1'b0;
        cv_mode = 0; cd_noise = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_col_idx", int'(col_idx), 0);
        rst = 1'b0;

        // Zero-wait sweep of five columns
        shift_base = shift_cnt;
        push_ev(0, 1, 3); push_ev(0, 2, 4); push_ev(0, 3, 5); push_ev(1, 0, 5);
        cv_mode = 1;
        do_start(5);
        run_until_done(200);
        cv_mode = 0;
        check("t1_total_shifts", shift_cnt - shift_base, 5);
        check("t1_queue_drained", exp_q.size() - rd_ptr, 0);

        // Slow fetch, with stray start and comp_done pulses mid-sweep
        @(posedge clk); #1;
        shift_base = shift_cnt;
        push_ev(0, 1, 3); push_ev(1, 0, 3);
        cv_mode  = 2;
        cd_noise = 1'b1;
        do_start(3);
        base = done_cnt;
        hit  = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk);
            #1;
            start    = (i % 4 == 1);
            img_cols = CNT_W'(9);
            hit      = (done_cnt != base);
        end
        start = 1'b0;
        check("t2_done_within_budget", int'(hit), 1);
        cd_noise = 1'b0;
        cv_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t2_total_shifts", shift_cnt - shift_base, 3);
        check("t2_no_restart", int'(busy), 0);
        check("t2_queue_drained", exp_q.size() - rd_ptr, 0);

        // Strips too narrow for a window
        foreach (exp_q[i]) begin end
        for (int k = 0; k < 2; k++) begin
            shift_base = shift_cnt;
            base = any_act;
            push_ev(1, 0, 0);
            cv_mode = 1;
            do_start(k == 0 ? 2 : 0);
            repeat (3) @(posedge clk);
            #1;
            check("short_no_activity", any_act - base, 0);
            check("short_back_idle", int'(busy), 0);
        end
        cv_mode = 0;
        check("short_queue_drained", exp_q.size() - rd_ptr, 0);

        // Abort during the second window, then a fresh sweep
        shift_base = shift_cnt;
        push_ev(0, 1, 3); push_ev(0, 2, 4);
        cv_mode = 1;
        do_start(6);
        base = win_seen;
        hit  = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (win_seen >= base + 2);
        end
        check("abort_window_seen", int'(hit), 1);
        abort = 1'b1;
        base  = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b0;
        cv_mode = 0;
        check_idle_outputs("abort");
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - base, 0);
        check("abort_queue_drained", exp_q.size() - rd_ptr, 0);
        shift_base = shift_cnt;
        push_ev(0, 1, 3); push_ev(0, 2, 4); push_ev(1, 0, 4);
        cv_mode = 1;
        do_start(4);
        run_until_done(200);
        cv_mode = 0;
        check("restart_queue_drained", exp_q.size() - rd_ptr, 0);

        // Synchronous reset while a column is being shifted in
        @(posedge clk); #1;
        cv_mode = 1;
        do_start(5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_blocks_shift", int'(shift_rows), 0);
        base = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        check("rst_mid_col_idx", int'(col_idx), 0);
        cv_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt - base, 0);
        check("final_queue_drained", exp_q.size() - rd_ptr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
